// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
// Frame FSM states and data-width decoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic logic [3:0] data_bits(input logic [1:0] sel);
    return 4'd5 + {2'b00, sel};
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: bit-end strobe on the last cycle of a bit,
// mid strobe div/2 cycles into the bit.
module uart_bit_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] div,
  input  logic        load,
  input  logic        en,
  output logic        bit_end,
  output logic        mid
);

  logic [15:0] cnt;
  logic [15:0] half;

  // cnt runs div-1 .. 0; cycle k of a bit holds div-k
  assign half    = div - (div >> 1);
  assign bit_end = en && (cnt == 16'd0);
  assign mid     = en && (cnt == half);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (load || bit_end) begin
      cnt <= div - 16'd1;
    end else if (en) begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: TX and RX frame FSMs sharing one configuration.
// Each direction owns one bit timer.
module uart_transceiver (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_en_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        tx_o,
  output logic        tx_busy_o,
  input  logic        rx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        rx_busy_o,
  output logic        err_o,
  input  logic        err_clr_i
);
  import uart_pkg::*;

  state_t      tx_state;
  logic [7:0]  tx_sh;
  logic [3:0]  tx_nbits;
  logic [3:0]  tx_idx;
  logic        tx_par_en;
  logic        tx_stop2;
  logic        tx_par;
  logic        tx_stop_cnt;
  logic        tx_fire;
  logic        tx_end;
  logic        unused_tx_mid;

  assign tx_ready_o = rstn_i && cfg_en_i
                   && (tx_state == IDLE);
  assign tx_fire = tx_valid_i && tx_ready_o;

  uart_bit_timer u_tx_timer (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .div     (cfg_div_i),
    .load    (tx_fire),
    .en      (tx_state != IDLE),
    .bit_end (tx_end),
    .mid     (unused_tx_mid)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_state    <= IDLE;
      tx_o        <= 1'b1;
      tx_busy_o   <= 1'b0;
      tx_sh       <= 8'd0;
      tx_nbits    <= 4'd0;
      tx_idx      <= 4'd0;
      tx_par_en   <= 1'b0;
      tx_stop2    <= 1'b0;
      tx_par      <= 1'b0;
      tx_stop_cnt <= 1'b0;
    end else begin
      unique case (tx_state)
        IDLE: if (tx_fire) begin
          tx_state  <= START;
          tx_o      <= 1'b0;
          tx_busy_o <= 1'b1;
          tx_sh     <= tx_data_i;
          tx_nbits  <= data_bits(cfg_bits_i);
          tx_par_en <= cfg_parity_en_i;
          tx_stop2  <= cfg_stop_bits_i;
        end
        START: if (tx_end) begin
          tx_state <= DATA;
          tx_o     <= tx_sh[0];
          tx_par   <= tx_sh[0];
          tx_sh    <= tx_sh >> 1;
          tx_idx   <= 4'd1;
        end
        DATA: if (tx_end) begin
          if (tx_idx == tx_nbits) begin
            tx_state    <= tx_par_en ? PARITY : STOP;
            tx_o        <= tx_par_en ? tx_par : 1'b1;
            tx_stop_cnt <= 1'b0;
          end else begin
            tx_o   <= tx_sh[0];
            tx_par <= tx_par ^ tx_sh[0];
            tx_sh  <= tx_sh >> 1;
            tx_idx <= tx_idx + 4'd1;
          end
        end
        PARITY: if (tx_end) begin
          tx_state    <= STOP;
          tx_o        <= 1'b1;
          tx_stop_cnt <= 1'b0;
        end
        STOP: if (tx_end) begin
          if (tx_stop2 && !tx_stop_cnt) begin
            tx_stop_cnt <= 1'b1;
          end else begin
            tx_state  <= IDLE;
            tx_busy_o <= 1'b0;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  state_t      rx_state;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_s3;
  logic [7:0]  rx_sh;
  logic [3:0]  rx_idx;
  logic [3:0]  rx_nbits;
  logic [7:0]  rx_word;
  logic        rx_par;
  logic        rx_par_bad;
  logic        rx_start;
  logic        rx_mid;
  logic        unused_rx_end;

  assign rx_nbits = data_bits(cfg_bits_i);
  // bits were shifted in from the top; realign to bit 0
  assign rx_word  = rx_sh >> (4'd8 - rx_nbits);
  assign rx_start = (rx_state == IDLE) && cfg_en_i
                 && rx_s3 && !rx_s2;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  uart_bit_timer u_rx_timer (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .div     (cfg_div_i),
    .load    (rx_start),
    .en      (rx_state != IDLE),
    .bit_end (unused_rx_end),
    .mid     (rx_mid)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_state   <= IDLE;
      rx_busy_o  <= 1'b0;
      rx_sh      <= 8'd0;
      rx_idx     <= 4'd0;
      rx_par     <= 1'b0;
      rx_par_bad <= 1'b0;
      rx_data_o  <= 8'd0;
      rx_valid_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      if (err_clr_i) err_o <= 1'b0;
      unique case (rx_state)
        IDLE: if (rx_start) begin
          rx_state  <= START;
          rx_busy_o <= 1'b1;
        end
        START: if (rx_mid) begin
          if (rx_s2) begin
            rx_state  <= IDLE;
            rx_busy_o <= 1'b0;
          end else begin
            rx_state   <= DATA;
            rx_idx     <= 4'd0;
            rx_par     <= 1'b0;
            rx_par_bad <= 1'b0;
          end
        end
        DATA: if (rx_mid) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_par <= rx_par ^ rx_s2;
          rx_idx <= rx_idx + 4'd1;
          if (rx_idx + 4'd1 == rx_nbits)
            rx_state <= cfg_parity_en_i ? PARITY : STOP;
        end
        PARITY: if (rx_mid) begin
          rx_par_bad <= rx_par ^ rx_s2;
          rx_state   <= STOP;
        end
        STOP: if (rx_mid) begin
          rx_state  <= IDLE;
          rx_busy_o <= 1'b0;
          // error set is placed after the clear so it wins
          if (!rx_s2 || rx_par_bad) begin
            err_o <= 1'b1;
          end else begin
            rx_data_o  <= rx_word;
            rx_valid_o <= 1'b1;
            if (rx_valid_o && !rx_ready_i) err_o <= 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: directed steps with
// random data checked against a frame-level reference model.
module tb_uart_transceiver;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cfg_div;
  logic        cfg_en;
  logic        cfg_parity_en;
  logic [1:0]  cfg_bits;
  logic        cfg_stop_bits;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_o;
  logic        tx_busy;
  logic        rx_line;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_busy;
  logic        err;
  logic        err_clr;
  logic        loop;
  logic        rx_drv;

  int errors = 0;
  int checks = 0;
  int vcyc = 0;
  logic [7:0] rx_got[$];
  bit frame[$];

  assign rx_line = loop ? tx_o : rx_drv;

  always #5 clk = ~clk;

  uart_transceiver dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cfg_div_i       (cfg_div),
    .cfg_en_i        (cfg_en),
    .cfg_parity_en_i (cfg_parity_en),
    .cfg_bits_i      (cfg_bits),
    .cfg_stop_bits_i (cfg_stop_bits),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready),
    .tx_o            (tx_o),
    .tx_busy_o       (tx_busy),
    .rx_i            (rx_line),
    .rx_data_o       (rx_data),
    .rx_valid_o      (rx_valid),
    .rx_ready_i      (rx_ready),
    .rx_busy_o       (rx_busy),
    .err_o           (err),
    .err_clr_i       (err_clr)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      vcyc++;
      if (rx_ready) rx_got.push_back(rx_data);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Reference frame: start, LSB-first data, even parity, stops
  task automatic make_frame(input logic [7:0] d, input int nb,
                            input bit pe, input int ns,
                            input bit par_flip, input bit stop_v);
    int ones;
    frame = {};
    frame.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      frame.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) frame.push_back(bit'(ones % 2) ^ par_flip);
    for (int i = 0; i < ns; i++) frame.push_back(stop_v);
  endtask

  task automatic set_cfg(input int dv, input logic [1:0] b,
                         input logic pe, input logic s2);
    cfg_div       = 16'(dv);
    cfg_bits      = b;
    cfg_parity_en = pe;
    cfg_stop_bits = s2;
  endtask

  task automatic tx_frame(input logic [7:0] d, input string tag);
    int n, bad, bsy, nrdy, tot, dv;
    dv = int'(cfg_div);
    make_frame(d, int'(cfg_bits) + 5, cfg_parity_en,
               int'(cfg_stop_bits) + 1, 1'b0, 1'b1);
    tot = frame.size() * dv;
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    bad = 0;
    bsy = 0;
    nrdy = 0;
    for (int c = 1; c <= tot; c++) begin
      if (tx_o !== frame[(c - 1) / dv]) bad++;
      if (tx_busy === 1'b1) bsy++;
      if (tx_ready !== 1'b1) nrdy++;
      @(negedge clk);
    end
    check({tag, "_wave"}, 32'(bad), 32'd0);
    check({tag, "_busy"}, 32'(bsy), 32'(tot));
    check({tag, "_rdylo"}, 32'(nrdy), 32'(tot));
    check({tag, "_end"}, {30'd0, tx_busy, tx_o}, 32'd1);
  endtask

  task automatic inject(input int dv);
    foreach (frame[i]) begin
      rx_drv = frame[i];
      repeat (dv) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int base, vb, n, bsy, t0, t1, nrdy, dv;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic [1:0] b;
    logic pe, s2;

    rstn     = 1'b0;
    cfg_en   = 1'b1;
    tx_data  = 8'd0;
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    err_clr  = 1'b0;
    loop     = 1'b1;
    rx_drv   = 1'b1;
    set_cfg(434, 2'b11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_tx", {29'd0, tx_o, tx_ready, tx_busy}, 32'd4);
    check("rst_rx", {29'd0, rx_valid, rx_busy, err}, 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    rstn = 1'b1;
    #1;
    check("rdy_out_of_rst", 32'(tx_ready), 32'd1);
    @(negedge clk);

    // 8N1 at 115200-style divider
    tx_frame(8'h55, "t55");

    // loopback: 0x00 0x00 0xFF then five 0x00
    set_cfg(int'($urandom_range(8, 40)), 2'b11, 1'b0, 1'b0);
    exp_q = '{8'h00, 8'h00, 8'hFF, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00};
    base = rx_got.size();
    vb = vcyc;
    foreach (exp_q[i]) tx_frame(exp_q[i], "lb");
    repeat (4) @(negedge clk);
    check("lb_count", 32'(rx_got.size() - base), 32'd8);
    check("lb_pulses", 32'(vcyc - vb), 32'd8);
    for (int i = 0; i < 8; i++)
      if (base + i < rx_got.size())
        check("lb_data", 32'(rx_got[base + i]), 32'(exp_q[i]));
    check("lb_err", 32'(err), 32'd0);

    // random formats, upper data bits random and ignored
    for (int k = 0; k < 5; k++) begin
      dv = int'($urandom_range(8, 40));
      d  = 8'($urandom);
      b  = 2'($urandom);
      pe = 1'($urandom);
      s2 = 1'($urandom);
      set_cfg(dv, b, pe, s2);
      base = rx_got.size();
      tx_frame(d, "rnd");
      repeat (4) @(negedge clk);
      check("rnd_count", 32'(rx_got.size() - base), 32'd1);
      if (rx_got.size() > base)
        check("rnd_data", 32'(rx_got[base]),
              32'(d & 8'((1 << (int'(b) + 5)) - 1)));
      check("rnd_err", 32'(err), 32'd0);
    end

    // back-to-back 8N2 0x41
    set_cfg(20, 2'b11, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    tx_data  = 8'h41;
    tx_valid = 1'b1;
    t0 = -1;
    t1 = -1;
    nrdy = 0;
    n = 0;
    while (t1 < 0 && n < 2000) begin
      if (tx_ready === 1'b1) begin
        if (t0 < 0) t0 = n;
        else t1 = n;
      end else if (t0 >= 0) begin
        nrdy++;
      end
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    check("b2b_first", 32'(t0), 32'd0);
    check("b2b_space", 32'(t1 - t0), 32'(11 * 20 + 1));
    check("b2b_rdylo", 32'(nrdy), 32'(11 * 20));
    n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done", 32'(tx_ready), 32'd1);

    // injected bad parity: 8E1 0x03 with parity 1
    loop = 1'b0;
    set_cfg(16, 2'b11, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vb = vcyc;
    make_frame(8'h03, 8, 1'b1, 1, 1'b1, 1'b1);
    inject(16);
    repeat (4) @(negedge clk);
    check("par_novalid", 32'(vcyc - vb), 32'd0);
    check("par_err", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'd0);

    // stop bit = 0
    set_cfg(16, 2'b11, 1'b0, 1'b0);
    vb = vcyc;
    make_frame(8'hA5, 8, 1'b0, 1, 1'b0, 1'b0);
    inject(16);
    repeat (4) @(negedge clk);
    check("stop_novalid", 32'(vcyc - vb), 32'd0);
    check("stop_err", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // 100-cycle low glitch at div 434
    set_cfg(434, 2'b11, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    vb = vcyc;
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b1;
    n = 0;
    while (rx_busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("glitch_idle", 32'(rx_busy), 32'd0);
    bsy = 0;
    repeat (2 * 434) begin
      @(negedge clk);
      if (rx_busy !== 1'b0) bsy++;
    end
    check("glitch_quiet", 32'(bsy), 32'd0);
    check("glitch_err", 32'(err), 32'd0);
    check("glitch_novalid", 32'(vcyc - vb), 32'd0);

    // overrun with consumer stalled
    set_cfg(16, 2'b11, 1'b0, 1'b0);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    make_frame(8'h12, 8, 1'b0, 1, 1'b0, 1'b1);
    inject(16);
    repeat (3) @(negedge clk);
    check("ovr_first", {23'd0, rx_valid, rx_data}, 32'h112);
    check("ovr_first_err", 32'(err), 32'd0);
    make_frame(8'h34, 8, 1'b0, 1, 1'b0, 1'b1);
    inject(16);
    repeat (3) @(negedge clk);
    check("ovr_data", 32'(rx_data), 32'h34);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_err", 32'(err), 32'd1);

    // reset in the middle of both frames
    rx_drv   = 1'b0;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_busy", {30'd0, tx_busy, rx_busy}, 32'd3);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_tx", {29'd0, tx_o, tx_ready, tx_busy}, 32'd4);
    check("mid_rst_rx", {29'd0, rx_valid, rx_busy, err}, 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'd0);
    rx_drv = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
